// File: rtl/fir_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fir_pkg : shared types, constants and sizing helpers for the FIR core |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        MAC   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } fir_state_t;

    // Unity gain for the default 16-bit Q1.15 coefficient format
    localparam logic [15:0] c_COEFF_ONE = 16'h8000;

    function automatic int acc_width(input int data_w, input int num_taps);
        return 2 * data_w + $clog2(num_taps) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_file.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fir_tap_file : coefficient store, sample history and MAC read port    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fir_tap_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 4,
    localparam int IDX_W   = $clog2(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_coeff_we,
    input  logic [DATA_W-1:0] i_coeff_data,
    input  logic              i_shift_en,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_coeff,
    output logic [DATA_W-1:0] o_rd_hist,
    output logic              o_coeffs_loaded
);

    logic [DATA_W-1:0] r_coeff [NUM_TAPS];
    logic [DATA_W-1:0] r_hist  [NUM_TAPS];
    logic [IDX_W-1:0]  r_ptr;
    logic              r_loaded;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coeff[i] <= '0;
                r_hist[i]  <= '0;
            end
            r_ptr    <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (i_coeff_we) begin
                r_coeff[r_ptr] <= i_coeff_data;
                // Full set present once the pointer wraps; sticky until reset
                if (r_ptr == IDX_W'(NUM_TAPS - 1)) begin
                    r_ptr    <= '0;
                    r_loaded <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + IDX_W'(1);
                end
            end
            if (i_shift_en) begin
                r_hist[0] <= i_sample;
                for (int i = 1; i < NUM_TAPS; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
        end
    end

    assign o_rd_coeff      = r_coeff[i_rd_idx];
    assign o_rd_hist       = r_hist[i_rd_idx];
    assign o_coeffs_loaded = r_loaded;

endmodule
`default_nettype wire

// File: rtl/param_fir_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | param_fir_filter : sequential one-MAC-per-cycle FIR with status flags |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module param_fir_filter
    import fir_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_TAPS     = 4,
    parameter int SUB_ODD      = 1,
    parameter int SATURATE     = 1,
    parameter int SAMPLE_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              err,
    output logic              one_k_samples,
    output logic              coeffs_loaded
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int ACC_W = acc_width(DATA_W, NUM_TAPS);
    localparam int CNT_W = $clog2(SAMPLE_LIMIT + 1);

    fir_state_t               r_state, w_next_state;
    logic                     r_dr_d, r_lc_d;
    logic                     w_load_req, w_data_req;
    logic [DATA_W-1:0]        r_req_data;
    logic [IDX_W-1:0]         r_tap;
    logic signed [ACC_W-1:0]  r_acc, w_acc_next, w_prod_ext;
    logic [CNT_W-1:0]         r_count;
    logic                     r_modwait, r_err, r_one_k;
    logic [DATA_W-1:0]        r_fir_out, w_fir_res;
    logic                     w_coeff_we, w_shift_en, w_mac_en, w_done, w_err_st;
    logic                     w_loaded, w_underflow, w_overflow, w_sub;
    logic [DATA_W-1:0]        w_rd_coeff, w_rd_hist;
    logic [2*DATA_W-1:0]      w_prod_full, w_prod_shr;

    assign w_load_req = load_coeff & ~r_lc_d;
    assign w_data_req = data_ready & ~r_dr_d;

    fir_tap_file #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_tap_file (
        .clk             (clk),
        .rst             (reset),
        .i_coeff_we      (w_coeff_we),
        .i_coeff_data    (r_req_data),
        .i_shift_en      (w_shift_en),
        .i_sample        (r_req_data),
        .i_rd_idx        (r_tap),
        .o_rd_coeff      (w_rd_coeff),
        .o_rd_hist       (w_rd_hist),
        .o_coeffs_loaded (w_loaded)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Requests only count in IDLE; a simultaneous load wins over a sample
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_load_req)      w_next_state = LOAD;
                else if (w_data_req) w_next_state = w_loaded ? SHIFT : ERR;
            end
            LOAD:    w_next_state = IDLE;
            SHIFT:   w_next_state = MAC;
            MAC:     if (r_tap == IDX_W'(NUM_TAPS - 1)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_coeff_we = (r_state == LOAD);
        w_shift_en = (r_state == SHIFT);
        w_mac_en   = (r_state == MAC);
        w_done     = (r_state == DONE);
        w_err_st   = (r_state == ERR);
    end

    // Q1.(DATA_W-1) product, truncated back to sample scale
    assign w_prod_full = {{DATA_W{1'b0}}, w_rd_hist} * {{DATA_W{1'b0}}, w_rd_coeff};
    assign w_prod_shr  = w_prod_full >> (DATA_W - 1);
    assign w_prod_ext  = $signed({{(ACC_W - 2*DATA_W){1'b0}}, w_prod_shr});
    assign w_sub       = (SUB_ODD != 0) && r_tap[0];
    assign w_acc_next  = w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);

    assign w_underflow = r_acc[ACC_W-1];
    assign w_overflow  = !w_underflow && (|r_acc[ACC_W-2:DATA_W]);
    assign w_fir_res   = (SATURATE != 0 && w_underflow) ? '0 :
                         (SATURATE != 0 && w_overflow)  ? '1 : r_acc[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dr_d     <= 1'b0;
            r_lc_d     <= 1'b0;
            r_req_data <= '0;
            r_tap      <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_modwait  <= 1'b0;
            r_err      <= 1'b0;
            r_one_k    <= 1'b0;
            r_fir_out  <= '0;
        end else begin
            r_dr_d    <= data_ready;
            r_lc_d    <= load_coeff;
            r_modwait <= (w_next_state != IDLE);
            r_one_k   <= 1'b0;
            if (r_state == IDLE && (w_load_req || w_data_req)) begin
                r_req_data <= w_load_req ? fir_coefficient : sample_data;
            end
            if (w_shift_en) begin
                r_acc <= '0;
                r_tap <= '0;
            end
            if (w_mac_en) begin
                r_acc <= w_acc_next;
                r_tap <= r_tap + IDX_W'(1);
            end
            if (w_coeff_we) r_err <= 1'b0;
            if (w_err_st)   r_err <= 1'b1;
            if (w_done) begin
                r_fir_out <= w_fir_res;
                r_err     <= w_underflow | w_overflow;
                if (r_count == CNT_W'(SAMPLE_LIMIT - 1)) begin
                    r_count <= '0;
                    r_one_k <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign modwait       = r_modwait;
    assign fir_out       = r_fir_out;
    assign err           = r_err;
    assign one_k_samples = r_one_k;
    assign coeffs_loaded = w_loaded;

endmodule
`default_nettype wire
